ternary_mem_arbiter: RTL
========================

# ternary_mem_arbiter

Shares the single-port ternary RAM between the CPU core and the program loader, replacing the static state-based memory multiplexer in the system top. Performs per-cycle arbitration with round-robin fairness and bounded burst ownership, routes synchronous read data back to the requester that issued the read, and rejects addresses containing an invalid trit encoding. Sits between the `cpu`/`program_loader` memory ports and the `memory` instance.

## Interface
Parameters:
- WORD_SIZE, from parameters.vh: trits per data word; buses are 2*WORD_SIZE bits (2 bits/trit).
- MEM_ADDR_SIZE, from parameters.vh: trits per address; buses are 2*MEM_ADDR_SIZE bits.
- BURST_LEN, 4: maximum consecutive grants to one owner while the other requester waits; range 1..15.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_req  in  1  loader request valid.
- ld_we  in  1  loader write (1) or read (0).
- ld_addr  in  2*MEM_ADDR_SIZE  loader address.
- ld_wdata  in  2*WORD_SIZE  loader write data.
- ld_gnt  out  1  loader request accepted this cycle.
- ld_err  out  1  loader request rejected for an invalid address trit, pulsed in the grant cycle.
- cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_gnt, cpu_err: same as the `ld_*` ports, for the CPU.
- rvalid  out  1  read data valid, one cycle after a granted read.
- rowner  out  1  owner of the current rvalid: 0 = loader, 1 = CPU.
- mem_write  out  1  RAM write enable.
- mem_read  out  1  RAM read enable.
- mem_addr  out  2*MEM_ADDR_SIZE  RAM address.
- mem_write_data  out  2*WORD_SIZE  RAM write data.

Read data is not re-registered. Requesters take `mem_read_data` directly, qualified by `rvalid` and `rowner`.

## Operation
- At most one request is granted per cycle. Grant is combinational from `*_req` and the registered arbiter state.
- State machine:
  - IDLE: no owner. If exactly one requester is active, that requester is granted. If both are active, the requester not equal to `last` is granted. The next state is OWN_<winner>, with `burst` set to 1.
  - OWN_X (X is LD or CPU): if X requests and either (the other requester is idle) or (`burst` < BURST_LEN), X is granted and `burst` increments, saturating. Otherwise, if the other requester Y is active, Y is granted, the next state is OWN_Y, and `burst` is set to 1. If no requester is active, the next state is IDLE.
- `last` is updated to the granted requester on every grant.
- Address check: any trit equal to 2'b11 in the granted address is invalid. In that case:
  - the requester still receives `gnt`;
  - `*_err` is asserted;
  - `mem_write` and `mem_read` stay 0;
  - no `rvalid` follows.
- Valid granted write: `mem_write`=1 and the address and data are passed through.
- Valid granted read: `mem_read`=1. The winner is registered into `rowner`, and `rvalid` is asserted in the next cycle.
- When nothing is granted: `mem_*` enables are 0, and `mem_addr`/`mem_write_data` are driven to 0.
- Requesters hold `req`, `we`, `addr` and `wdata` stable until they see `gnt`. They may change the request in the cycle after a grant.

## Timing
- Reset (synchronous) sets:
  - state = IDLE;
  - `last` = CPU, so the loader wins the first tie;
  - `burst` = 0;
  - `rvalid` = 0;
  - `rowner` = 0.
  - All combinational outputs are 0 while `reset` is high, regardless of the requests.
- Grant latency: 0 cycles, same cycle as the request. Write completes at the grant edge. Read data latency is 1 cycle.
- Back-to-back reads from alternating owners produce `rvalid` on consecutive cycles with `rowner` tracking each read.
- Reset asserted in the cycle after a read grant: `rvalid` is forced to 0 and the read result is dropped.
- Simultaneous requests when `burst` == BURST_LEN: the grant switches owner. The starved requester waits at most BURST_LEN cycles.
- BURST_LEN=1 gives strict alternation under contention.

## Configuration
- `MEM_ARB_STATS_EN` defined: adds the output ports `ld_grant_cnt` and `cpu_grant_cnt` (16 bits each, binary, saturating at 16'hFFFF) and `err_cnt` (8 bits, saturating). All three increment on the corresponding grant or error and are cleared by reset.
- `MEM_ARB_STATS_EN` undefined: these ports and their counters do not exist, and arbitration behaviour is identical.

## Structure
- Trit encodings (`TRIT_NEG`, `TRIT_ZERO`, `TRIT_POS`, `TRIT_INVALID` = 2'b11), WORD_SIZE, MEM_ADDR_SIZE and the owner codes (`OWN_LD` = 0, `OWN_CPU` = 1) belong in the shared parameters.vh. Arbiter state encodings are local to the block.
- One sub-module, `trit_addr_check`: combinational, parameterised by trit count, outputs 1 if any trit is 2'b11. The arbiter instantiates it twice, once per requester address.

## Test plan
- Reset, then `ld_req`=1 write to address 0 with data 0x1 → `ld_gnt`=1 and `mem_write`=1 in the same cycle; `cpu_gnt`=0.
- Both requesters issue continuous reads, BURST_LEN=4 → the grant sequence is LD,LD,LD,LD,CPU,CPU,CPU,CPU,LD…; each `rvalid` has `rowner` matching the read issued one cycle earlier.
- CPU read with an address containing a 2'b11 trit → `cpu_gnt`=1, `cpu_err`=1, `mem_read`=0, no `rvalid` next cycle; with `MEM_ARB_STATS_EN` defined, `err_cnt`=1.
- Only the CPU requests for 10 cycles → the CPU is granted in all 10 cycles (no burst cutoff while uncontested).
- Reset asserted in the cycle after a loader read grant → `rvalid`=0 and the state returns to IDLE; the next tie goes to the loader.
- With `MEM_ARB_STATS_EN` defined, 3 loader grants and 2 CPU grants → `ld_grant_cnt`=3 and `cpu_grant_cnt`=2.

Source files
------------

// File: rtl/ternary_mem_arbiter_pkg.sv
// Shared ternary machine constants: word/address sizes, 2-bit trit encodings
// and requester owner codes used by the memory arbiter.
package ternary_mem_arbiter_pkg;

  localparam int WORD_SIZE     = 9;
  localparam int MEM_ADDR_SIZE = 6;

  localparam logic [1:0] TRIT_NEG     = 2'b10;
  localparam logic [1:0] TRIT_ZERO    = 2'b00;
  localparam logic [1:0] TRIT_POS     = 2'b01;
  localparam logic [1:0] TRIT_INVALID = 2'b11;

  localparam logic OWN_LD  = 1'b0;
  localparam logic OWN_CPU = 1'b1;

  function automatic logic trit_is_valid(input logic [1:0] t);
    return (t == TRIT_NEG) || (t == TRIT_ZERO) || (t == TRIT_POS);
  endfunction

endpackage

// File: rtl/trit_addr_check.sv
// Flags a ternary address that holds at least one invalid (2'b11) trit.
module trit_addr_check
  import ternary_mem_arbiter_pkg::*;
#(
  parameter int N_TRITS = MEM_ADDR_SIZE
) (
  input  logic [2*N_TRITS-1:0] addr,
  output logic                 invalid
);

  always_comb begin
    invalid = 1'b0;
    for (int i = 0; i < N_TRITS; i++) begin
      if (!trit_is_valid(addr[2*i +: 2])) invalid = 1'b1;
    end
  end

endmodule

// File: rtl/ternary_mem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the single-port ternary RAM
// between loader and CPU. Optional grant/error counters under MEM_ARB_STATS_EN.
module ternary_mem_arbiter
  import ternary_mem_arbiter_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ld_req,
  input  logic                       ld_we,
  input  logic [2*MEM_ADDR_SIZE-1:0] ld_addr,
  input  logic [2*WORD_SIZE-1:0]     ld_wdata,
  output logic                       ld_gnt,
  output logic                       ld_err,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [2*MEM_ADDR_SIZE-1:0] cpu_addr,
  input  logic [2*WORD_SIZE-1:0]     cpu_wdata,
  output logic                       cpu_gnt,
  output logic                       cpu_err,
  output logic                       rvalid,
  output logic                       rowner,
  output logic                       mem_write,
  output logic                       mem_read,
  output logic [2*MEM_ADDR_SIZE-1:0] mem_addr,
  output logic [2*WORD_SIZE-1:0]     mem_write_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]                ld_grant_cnt,
  output logic [15:0]                cpu_grant_cnt,
  output logic [7:0]                 err_cnt
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN_LD, ST_OWN_CPU} state_e;

  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  state_e     state_q, state_d;
  logic [3:0] burst_q, burst_d, burst_inc;
  logic       last_q, last_d;
  logic       rvalid_q, rvalid_d;
  logic       rowner_q, rowner_d;
  logic       gnt_ld, gnt_cpu;
  logic       ld_bad, cpu_bad;

  trit_addr_check #(.N_TRITS(MEM_ADDR_SIZE)) u_ld_check (
    .addr    (ld_addr),
    .invalid (ld_bad)
  );

  trit_addr_check #(.N_TRITS(MEM_ADDR_SIZE)) u_cpu_check (
    .addr    (cpu_addr),
    .invalid (cpu_bad)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    last_d    = last_q;
    gnt_ld    = 1'b0;
    gnt_cpu   = 1'b0;
    burst_inc = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_req && (!cpu_req || last_q == OWN_CPU)) begin
          gnt_ld  = 1'b1;
          state_d = ST_OWN_LD;
          burst_d = 4'd1;
        end else if (cpu_req) begin
          gnt_cpu = 1'b1;
          state_d = ST_OWN_CPU;
          burst_d = 4'd1;
        end
      end
      ST_OWN_LD: begin
        if (ld_req && (!cpu_req || burst_q < BURST_MAX)) begin
          gnt_ld  = 1'b1;
          burst_d = burst_inc;
        end else if (cpu_req) begin
          gnt_cpu = 1'b1;
          state_d = ST_OWN_CPU;
          burst_d = 4'd1;
        end else begin
          state_d = ST_IDLE;
          burst_d = 4'd0;
        end
      end
      ST_OWN_CPU: begin
        if (cpu_req && (!ld_req || burst_q < BURST_MAX)) begin
          gnt_cpu = 1'b1;
          burst_d = burst_inc;
        end else if (ld_req) begin
          gnt_ld  = 1'b1;
          state_d = ST_OWN_LD;
          burst_d = 4'd1;
        end else begin
          state_d = ST_IDLE;
          burst_d = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (gnt_ld)       last_d = OWN_LD;
    else if (gnt_cpu) last_d = OWN_CPU;
    // Outputs stay quiet while reset is held, whatever the requesters do.
    if (reset) begin
      gnt_ld  = 1'b0;
      gnt_cpu = 1'b0;
    end
  end

  always_comb begin
    mem_addr       = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    if (gnt_ld) begin
      mem_addr       = ld_addr;
      mem_write_data = ld_wdata;
      mem_write      = ld_we && !ld_bad;
      mem_read       = !ld_we && !ld_bad;
    end else if (gnt_cpu) begin
      mem_addr       = cpu_addr;
      mem_write_data = cpu_wdata;
      mem_write      = cpu_we && !cpu_bad;
      mem_read       = !cpu_we && !cpu_bad;
    end
    rvalid_d = mem_read;
    rowner_d = mem_read ? gnt_cpu : rowner_q;
  end

  assign ld_gnt  = gnt_ld;
  assign cpu_gnt = gnt_cpu;
  assign ld_err  = gnt_ld && ld_bad;
  assign cpu_err = gnt_cpu && cpu_bad;
  // A read granted just before reset is dropped immediately, not one cycle later.
  assign rvalid  = rvalid_q && !reset;
  assign rowner  = rowner_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      burst_q  <= 4'd0;
      last_q   <= OWN_CPU;
      rvalid_q <= 1'b0;
      rowner_q <= OWN_LD;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      rowner_q <= rowner_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] ld_cnt_q, ld_cnt_d, cpu_cnt_q, cpu_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    ld_cnt_d  = ld_cnt_q;
    cpu_cnt_d = cpu_cnt_q;
    err_cnt_d = err_cnt_q;
    if (gnt_ld && ld_cnt_q != 16'hFFFF)          ld_cnt_d  = ld_cnt_q + 16'd1;
    if (gnt_cpu && cpu_cnt_q != 16'hFFFF)        cpu_cnt_d = cpu_cnt_q + 16'd1;
    if ((ld_err || cpu_err) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ld_cnt_q  <= '0;
      cpu_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      ld_cnt_q  <= ld_cnt_d;
      cpu_cnt_q <= cpu_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ld_grant_cnt  = ld_cnt_q;
  assign cpu_grant_cnt = cpu_cnt_q;
  assign err_cnt       = err_cnt_q;
`endif

endmodule
